div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the DIV/DIVU instructions. It sits beside the EXE stage. EXE drives the operands and start_i, and holds its stall request to CTRL until ready_o rises. The 64-bit result ({remainder, quotient}) then travels down the pipeline as the HI/LO write data. The core is a radix-2 restoring divider that produces one quotient bit per cycle, with sign fix-up for signed operation.

---
 rtl/div_unit.sv | 168 ++++++++++++++++
 tb/tb_div_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient}; ready_o stays high while start_i is held.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic        signed_q, signed_d;
  logic        op1_sign_q, op1_sign_d;
  logic        op2_sign_q, op2_sign_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] abs1, abs2;
  logic [32:0] temp;
  logic [31:0] quot_fix, rem_fix;
  logic        iter_done;

  // Magnitudes of the raw operands; used only when a request is accepted.
  assign abs1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  assign temp      = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
  assign iter_done = cnt_q[5];

  // Sign fix-up uses the latched operand signs, not the live inputs.
  assign quot_fix = (signed_q && (op1_sign_q ^ op2_sign_q)) ?
                    (~dividend_q[31:0] + 32'd1) : dividend_q[31:0];
  assign rem_fix  = (signed_q && op1_sign_q) ?
                    (~dividend_q[64:33] + 32'd1) : dividend_q[64:33];

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= S_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          state_d = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: state_d = S_END;
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else if (iter_done) begin
          state_d = S_END;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d = S_FREE;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    signed_d   = signed_q;
    op1_sign_d = op1_sign_q;
    op2_sign_d = op2_sign_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      S_FREE: begin
        result_d = 64'd0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          cnt_d      = 6'd0;
          dividend_d = {32'd0, abs1, 1'b0};
          divisor_d  = abs2;
          signed_d   = signed_div_i;
          op1_sign_d = opdata1_i[31];
          op2_sign_d = opdata2_i[31];
        end
      end
      S_BYZERO: begin
        dividend_d = 65'd0;
        result_d   = 64'd0;
        ready_d    = 1'b1;
      end
      S_ON: begin
        if (annul_i) begin
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else if (!iter_done) begin
          if (temp[32]) begin
            dividend_d = {dividend_q[63:0], 1'b0};
          end else begin
            dividend_d = {temp[31:0], dividend_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          dividend_d = {rem_fix, dividend_q[32], quot_fix};
          result_d   = {rem_fix, quot_fix};
          ready_d    = 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = 64'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt_q      <= 6'd0;
      dividend_q <= 65'd0;
      divisor_q  <= 32'd0;
      signed_q   <= 1'b0;
      op1_sign_q <= 1'b0;
      op2_sign_q <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      signed_q   <= signed_d;
      op1_sign_q <= op1_sign_d;
      op2_sign_q <= op2_sign_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on each rising ready_o.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic        prev_ready = 1'b0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic, truncating division.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint na, nb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      na = {{32{a[31]}}, a};
      nb = {{32{b[31]}}, b};
    end else begin
      na = {32'd0, a};
      nb = {32'd0, b};
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every rising ready_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(ready_o), 64'd0);
      end else begin
        check("result", result_o, exp_q.pop_front());
      end
    end
    prev_ready <= ready_o;
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [63:0] exp, input int hold, input bit scramble,
                        input bit reset_end);
    int n;
    int lat;
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sg;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    exp_q.push_back(exp);
    lat = (b == 32'd0) ? 2 : 34;
    n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (scramble && n == 4) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sg;
      end
    end
    check("latency", 64'(n), 64'(lat));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, exp);
    end
    if (!reset_end) begin
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check("drop_ready", 64'(ready_o), 64'd0);
      check("drop_result", result_o, 64'd0);
    end else begin
      @(negedge clk);
      #2;
      resetn  = 1'b1;
      start_i = 1'b0;
      #1;
      check("rst_end_ready", 64'(ready_o), 64'd0);
      check("rst_end_result", result_o, 64'd0);
      @(negedge clk);
      resetn = 1'b0;
    end
  endtask

  task automatic idle_check(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (ready_o || result_o != 64'd0) bad++;
    end
    check(name, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sg;
    resetn       = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    #12;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b0;

    run_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 2, 1'b0, 1'b0);
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 0, 1'b0, 1'b0);
    run_op(32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 1, 1'b0, 1'b0);
    run_op(32'd55, 32'd0, 1'b1, 64'd0, 1, 1'b0, 1'b0);
    run_op(32'hDEADBEEF, 32'd0, 1'b0, 64'd0, 0, 1'b0, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 0, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 0, 1'b0, 1'b0);
    run_op(32'd12345, 32'd17, 1'b0, 64'h00000003_000002D6, 0, 1'b1, 1'b0);

    // Annul at edge 10, then a clean follow-up request.
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    idle_check("annul_idle", 40);
    run_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 0, 1'b0, 1'b0);

    // Reset in the middle of an iteration.
    @(negedge clk);
    opdata1_i = 32'd777; opdata2_i = 32'd5; signed_div_i = 1'b1; start_i = 1'b1;
    repeat (19) @(posedge clk);
    @(negedge clk);
    #2;
    resetn  = 1'b1;
    start_i = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b0;
    idle_check("rst_mid_idle", 40);

    // Reset while a result is being presented.
    run_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1, 1'b0, 1'b1);
    idle_check("rst_end_idle", 10);

    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_op(a, b, sg, ref_div(a, b, sg), $urandom_range(0, 2),
             1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
